// File: rtl/pmem_arbiter_if.sv
// Signal bundle between the I/D cache line ports, the arbiter and physical memory.
// slave: the arbiter's view. master: the surrounding caches and memory.
interface pmem_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  // I-cache port
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_wdata;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache port
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Physical memory port
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  // Current owner: 00 idle, 01 I-cache, 10 D-cache
  logic [1:0]        arb_owner;

  modport slave (
    input  i_read, i_write, i_address, i_wdata,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output arb_owner
  );

  modport master (
    output i_read, i_write, i_address, i_wdata,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  arb_owner
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Two-port line-memory arbiter: grants the I-cache or D-cache port one whole line
// transaction at a time, registers the winner's command toward physical memory and
// steers the response back to the owner. Ties go round-robin or to D (D_PRIO=1).
module pmem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned D_PRIO = 0
) (
  input logic           clk,
  input logic           rst_n,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIBusy = 2'b01,
    StDBusy = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;  // 1: D-cache was the most recent winner
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_act;
  logic d_act;
  logic win_d;

  assign i_act = bus.i_read | bus.i_write;
  assign d_act = bus.d_read | bus.d_write;
  // D wins when alone, under fixed priority, or when I was served last
  assign win_d = d_act & (~i_act | (D_PRIO != 0) | ~last_d_q);

  // Next-state: grant from idle and capture the winner's command; release on pmem_resp
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_d) begin
          state_d  = StDBusy;
          last_d_d = 1'b1;
          rd_d     = bus.d_read & ~bus.d_write;  // read+write executes as a write
          wr_d     = bus.d_write;
          addr_d   = bus.d_address;
          wdata_d  = bus.d_wdata;
        end else if (i_act) begin
          state_d  = StIBusy;
          last_d_d = 1'b0;
          rd_d     = bus.i_read & ~bus.i_write;
          wr_d     = bus.i_write;
          addr_d   = bus.i_address;
          wdata_d  = bus.i_wdata;
        end
      end
      StIBusy, StDBusy: begin
        // Requester inputs are not sampled while busy; address/wdata keep their value
        if (bus.pmem_resp) begin
          state_d = StIdle;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered pmem command; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Response is forwarded only to the owner; pmem_resp in idle is dropped
  assign bus.i_resp    = (state_q == StIBusy) & bus.pmem_resp;
  assign bus.d_resp    = (state_q == StDBusy) & bus.pmem_resp;
  assign bus.i_rdata   = bus.pmem_rdata;
  assign bus.d_rdata   = bus.pmem_rdata;
  assign bus.arb_owner = {state_q == StDBusy, state_q == StIBusy};

endmodule
